// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types for the toggle-handshake CDC ALU source/receiver pair
package cdc_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    MUL = 2'd1,
    SUB = 2'd2,
    MAX = 2'd3
  } alu_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUT     = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sync_nstage.sv
// rtl/sync_nstage.sv - parametrised multi-flop synchroniser for a single asynchronous bit
module sync_nstage #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/cdc_hs_alu_rx.sv
// rtl/cdc_hs_alu_rx.sv - toggle-handshake CDC receiver with a four-mode ALU and valid/ready result port
module cdc_hs_alu_rx
  import cdc_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_tgl,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [1:0]           mode,
  output logic                 ack_tgl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 busy,
  output logic                 proto_err
);

  localparam int OUT_W = 2 * WIDTH;

  rx_state_e        r_state;
  rx_state_e        w_state_nxt;
  logic             w_req_sync;
  logic             r_req_prev;
  logic             w_req_evt;
  logic             w_capture;
  logic             w_compute;
  logic             w_handshake;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  alu_mode_e        r_mode;
  logic [OUT_W-1:0] r_out;
  logic             r_out_valid;
  logic             r_ack;
  logic             r_perr;

  function automatic logic [OUT_W-1:0] alu_f(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input alu_mode_e        m
  );
    logic [OUT_W-1:0] ea;
    logic [OUT_W-1:0] eb;
    logic [OUT_W-1:0] res;
    ea = {{WIDTH{1'b0}}, a};
    eb = {{WIDTH{1'b0}}, b};
    case (m)
      ADD:     res = ea + eb;
      MUL:     res = ea * eb;
      SUB:     res = ea - eb;
      MAX:     res = (a > b) ? ea : eb;
      default: res = '0;
    endcase
    return res;
  endfunction

  sync_nstage #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (req_tgl),
    .q    (w_req_sync)
  );

  assign w_req_evt = w_req_sync ^ r_req_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_req_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_prev <= w_req_sync;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_compute   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_evt) begin
          w_capture   = 1'b1;
          w_state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        w_compute   = 1'b1;
        w_state_nxt = OUT;
      end
      OUT: begin
        if (r_out_valid && out_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands are only trusted at capture: the source holds them stable until it sees the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_mode <= ADD;
    end else if (w_capture) begin
      r_a    <= in_a;
      r_b    <= in_b;
      r_mode <= alu_mode_e'(mode);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_ack       <= 1'b0;
    end else if (w_compute) begin
      r_out       <= alu_f(r_a, r_b, r_mode);
      r_out_valid <= 1'b1;
    end else if (w_handshake) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_ack       <= ~r_ack;
    end
  end

  // A request arriving while a transaction is in flight is dropped and flagged until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr <= 1'b0;
    end else if (w_req_evt && (r_state != IDLE)) begin
      r_perr <= 1'b1;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign ack_tgl   = r_ack;
  assign proto_err = r_perr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_cdc_hs_alu_rx.sv
// tb/tb_cdc_hs_alu_rx.sv - directed self-checking bench for the CDC ALU receiver
module tb_cdc_hs_alu_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_tgl = 1'b0;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [1:0] mode = '0;
  logic       out_ready = 1'b0;
  logic       ack_tgl;
  logic       out_valid;
  logic [7:0] out;
  logic       busy;
  logic       proto_err;

  int   vectors = 0;
  int   miscompares = 0;
  int   exp_q[$];
  logic model_ack = 1'b0;

  cdc_hs_alu_rx #(
    .WIDTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_tgl  (req_tgl),
    .in_a     (in_a),
    .in_b     (in_b),
    .mode     (mode),
    .ack_tgl  (ack_tgl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .busy     (busy),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic int model_f(input int a, input int b, input int m);
    case (m)
      0:       return a + b;
      1:       return a * b;
      2:       return (a - b + 256) % 256;
      default: return (a > b) ? a : b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: every out_valid cycle must show the oldest pending result; a handshake retires it and flips the ack.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ack_tgl_model", ack_tgl, model_ack);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("valid_without_request", out_valid, 0);
        end else begin
          chk("out_model", out, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            model_ack = ~model_ack;
          end
        end
      end else begin
        chk("out_zero_when_invalid", out, 0);
      end
    end
  end

  task automatic toggle_req(input int a, input int b, input int m);
    @(posedge clk);
    #1;
    in_a    = 4'(a);
    in_b    = 4'(b);
    mode    = 2'(m);
    req_tgl = ~req_tgl;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    chk("valid_timeout", out_valid, 1);
  endtask

  task automatic txn(input int a, input int b, input int m, input int lit, input int hold);
    exp_q.push_back(model_f(a, b, m));
    out_ready = 1'b0;
    toggle_req(a, b, m);
    wait_valid();
    chk("result_literal", out, lit);
    chk("busy_in_out", busy, 1);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("held_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_after_handshake", out_valid, 0);
    chk("busy_after_handshake", busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out"}, out, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_ack"}, ack_tgl, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: reset, then an asynchronous reset pulse while idle
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst_held");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_idle");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Test 2: ADD 9+7 with ready already high; pin the latency edge by edge
    exp_q.push_back(model_f(9, 7, 0));
    out_ready = 1'b1;
    toggle_req(9, 7, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("lat_valid_after_edge3", out_valid, 0);
    chk("lat_busy_after_edge3", busy, 1);
    @(posedge clk);
    #1;
    chk("lat_valid_after_edge4", out_valid, 1);
    chk("add_9_7", out, 16);
    chk("ack_before_handshake", ack_tgl, 0);
    @(posedge clk);
    #1;
    chk("valid_one_cycle", out_valid, 0);
    chk("ack_after_add", ack_tgl, 1);
    out_ready = 1'b0;

    // Test 3: MUL 15*15 held under 5 cycles of backpressure
    txn(15, 15, 1, 225, 5);
    #1;
    chk("ack_after_mul", ack_tgl, 0);

    // Test 4: SUB wraps, then MAX
    txn(3, 5, 2, 254, 0);
    chk("ack_after_sub", ack_tgl, 1);
    txn(6, 12, 3, 12, 1);
    chk("ack_after_max", ack_tgl, 0);

    // Test 5: second toggle while the result waits in OUT
    exp_q.push_back(model_f(2, 3, 0));
    out_ready = 1'b0;
    toggle_req(2, 3, 0);
    wait_valid();
    chk("add_2_3", out, 5);
    chk("perr_before", proto_err, 0);
    toggle_req(2, 3, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("perr_set", proto_err, 1);
    chk("valid_still_held", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("no_second_result", out_valid, 0);
    chk("single_ack", ack_tgl, 1);
    chk("perr_sticky", proto_err, 1);
    chk("busy_idle_after_drop", busy, 0);

    // Test 6: asynchronous reset while a result is waiting in OUT
    exp_q.push_back(model_f(7, 9, 1));
    toggle_req(7, 9, 1);
    wait_valid();
    chk("mul_7_9", out, 63);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    req_tgl = 1'b0;
    exp_q.delete();
    model_ack = 1'b0;
    #1;
    chk_reset_vals("rst_in_out");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    txn(1, 1, 0, 2, 0);
    chk("ack_after_reset_txn", ack_tgl, 1);
    chk("perr_cleared", proto_err, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
